// File: rtl/ex_muldiv_unit.sv
// Execute stage: registered single-cycle ALU plus a 32-step iterative multiplier/divider with HI/LO.
// Define EX_DIV_EN to build the divider; without it DIV/DIVU retire as NOP.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_Dato1,
    input  logic [31:0] in_Dato2,
    input  logic [31:0] in_Extend,
    input  logic        in_ALUSrc,
    input  logic        in_RegDst,
    input  logic [4:0]  in_b20_16,
    input  logic [4:0]  in_b15_11,
    output logic        ou_stall,
    output logic        ou_valid,
    output logic [31:0] ou_result,
    output logic [31:0] ou_Dato_2,
    output logic [4:0]  ou_wreg,
    output logic        ou_zero
);
    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] hi, lo;
    logic [63:0] acc;        // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] opb_mag;
    logic        neg_res;

    logic [31:0] opb, a_mag, b_mag, alu_res;
    logic        accept, start, signed_op, a_neg, b_neg, alu_wb;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt, prod;

    assign opb       = in_ALUSrc ? in_Extend : in_Dato2;
    assign accept    = in_valid && (state == IDLE);
    assign signed_op = (in_op[3:2] == 2'b10) && !in_op[0];
    assign a_neg     = signed_op && in_Dato1[31];
    assign b_neg     = signed_op && opb[31];
    assign a_mag     = a_neg ? (~in_Dato1 + 32'd1) : in_Dato1;
    assign b_mag     = b_neg ? (~opb + 32'd1) : opb;
    assign alu_wb    = !in_op[3] || ((in_op[3:2] == 2'b11) && (in_op != 4'hF));
    assign ou_stall  = (state != IDLE);
    assign ou_zero   = (ou_result == 32'd0);

`ifdef EX_DIV_EN
    logic        is_div, neg_rem, div_zero;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        ge;
    logic [63:0] div_nxt;
    logic [31:0] quo_fix, rem_fix;

    assign start    = (in_op[3:2] == 2'b10);
    assign rem_sh   = acc[63:31];
    assign diff     = {1'b0, rem_sh} - {2'b00, opb_mag};
    assign ge       = !diff[33];
    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    assign div_nxt  = {(ge ? diff[31:0] : rem_sh[31:0]), acc[30:0], ge};
    assign quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_res ? (~acc[31:0] + 32'd1) : acc[31:0]);
    assign rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
`else
    assign start    = (in_op[3:1] == 3'b100);
`endif

    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb_mag} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};
    assign prod    = neg_res ? (~acc + 64'd1) : acc;

    always_comb begin
        alu_res = 32'd0;
        case (in_op)
            4'h0: alu_res = in_Dato1 + opb;
            4'h1: alu_res = in_Dato1 - opb;
            4'h2: alu_res = in_Dato1 & opb;
            4'h3: alu_res = in_Dato1 | opb;
            4'h4: alu_res = {31'd0, $signed(in_Dato1) < $signed(opb)};
            4'h5: alu_res = ~(in_Dato1 | opb);
            4'h6: alu_res = in_Dato1 ^ opb;
            4'h7: alu_res = {31'd0, in_Dato1 < opb};
            4'hC: alu_res = hi;
            4'hD: alu_res = lo;
            4'hE: alu_res = {opb[15:0], 16'd0};
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && start) state_nxt = BUSY;
            BUSY:    if (cnt == 5'd31) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 5'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            acc       <= 64'd0;
            opb_mag   <= 32'd0;
            neg_res   <= 1'b0;
`ifdef EX_DIV_EN
            is_div    <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
`endif
            ou_valid  <= 1'b0;
            ou_result <= 32'd0;
            ou_Dato_2 <= 32'd0;
            ou_wreg   <= 5'd0;
        end else begin
            ou_valid <= 1'b0;
            ou_wreg  <= 5'd0;
            if (accept) begin
                ou_valid  <= 1'b1;
                ou_Dato_2 <= in_Dato2;
                if (alu_wb) begin
                    ou_result <= alu_res;
                    ou_wreg   <= in_RegDst ? in_b15_11 : in_b20_16;
                end
            end
            case (state)
                IDLE: if (accept && start) begin
                    acc     <= {32'd0, a_mag};
                    opb_mag <= b_mag;
                    neg_res <= a_neg ^ b_neg;
                    cnt     <= 5'd0;
`ifdef EX_DIV_EN
                    is_div   <= in_op[1];
                    neg_rem  <= a_neg;
                    div_zero <= (opb == 32'd0);
`endif
                end
                BUSY: begin
                    cnt <= cnt + 5'd1;
`ifdef EX_DIV_EN
                    acc <= is_div ? div_nxt : mul_nxt;
`else
                    acc <= mul_nxt;
`endif
                end
                FINISH: begin
`ifdef EX_DIV_EN
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= prod[31:0];
                        hi <= prod[63:32];
                    end
`else
                    lo <= prod[31:0];
                    hi <= prod[63:32];
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
